// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder/subtractor: one 4-bit carry look-ahead slice is
// reused for every nibble, LSB first. Carry chains between nibbles through
// a flop. Valid/ready handshakes on both the operand and result sides.

// 4-bit carry look-ahead slice: generate/propagate with flattened carries.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum of products, so no carry ripples inside the slice.
    always_comb begin
        c    = '0;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    end

    assign s  = p ^ c[3:0];
    assign co = c[4];
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    // A one-nibble operand still needs a 1-bit index so the declaration is legal.
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;   // already inverted for subtract
    logic             carry;
    logic [IW-1:0]    idx;
    logic [3:0]       slice_s;
    logic             slice_co;

    cla4 u_slice (
        .a  (a_reg[4*idx +: 4]),
        .b  (b_reg[4*idx +: 4]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: accept, step through the nibbles, wait for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Datapath: latch operands on accept, then write one nibble of the result per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_reg <= sub ? ~b : b;
                    carry <= sub ? 1'b1 : cin;
                    sum   <= '0;
                    idx   <= '0;
                end
                RUN: begin
                    sum[4*idx +: 4] <= slice_s;
                    carry           <= slice_co;
                    if (idx == LAST) begin
                        idx  <= '0;
                        cout <= slice_co;
                        // Signed overflow: operand signs match but the result sign does not.
                        ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (slice_s[3] != a_reg[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl (WIDTH=16) against an integer reference model.
module tb_cla_seq_adder_ctrl;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 0;
    logic         rst = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 0;
    logic         sub = 0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int errors = 0;
    int checks = 0;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: signed/unsigned integer arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        int sx, sy, r, u;
        logic co, ov;
        logic [W-1:0] sm;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = sx - sy;
            co = (x >= y);
            sm = x - y;
        end else begin
            r  = sx + sy + int'(c);
            u  = int'(x) + int'(y) + int'(c);
            co = (u > 65535);
            sm = x + y + W'(c);
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, co, sm};
    endfunction

    // Drive one operation and wait for its result; lat = edges from accept to out_valid, -1 on timeout.
    // With junk set, operands change and in_valid/out_ready pulse while the operation runs.
    task automatic do_op(input logic [W-1:0] opa, input logic [W-1:0] opb,
                         input logic tcin, input logic tsub, input bit junk, output int lat);
        bit acc = 0;
        int n = 0;
        a = opa; b = opb; cin = tcin; sub = tsub; in_valid = 1;
        while (!acc && n < 20) begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 0;
        if (!acc) begin
            lat = -1;
            return;
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (junk && lat == 1) begin
                a = ~opa; b = opb ^ 16'h5a5a; cin = ~tcin; sub = ~tsub;
                in_valid = 1; out_ready = 1;
            end
            if (junk && lat == 2) begin
                in_valid = 0; out_ready = 0;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_result();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; a = 16'hffff; b = 16'h1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0) begin
            errors++;
            $display("FAIL reset: rdy/vld/busy/cout/ovf=%b sum=%h, want 10000 sum=0000",
                     {in_ready, out_valid, busy, cout, ovf}, sum);
        end
        rst = 0; in_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s, input string name);
        int lat;
        logic [W+1:0] e;
        e = model(x, y, c, s);
        do_op(x, y, c, s, 0, lat);
        checks++;
        if ({ovf, cout, sum} !== e || lat !== NS || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: ovf/cout/sum=%b/%b/%h lat=%0d busy=%b rdy=%b, want %b/%b/%h lat=%0d busy=1 rdy=0",
                     name, ovf, cout, sum, lat, busy, in_ready, e[W+1], e[W], e[W-1:0], NS);
        end
        release_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b, want 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit stable = 1;
        logic [W+1:0] e;
        e = model(16'h2468, 16'h1357, 1'b1, 1'b0);
        do_op(16'h2468, 16'h1357, 1'b1, 1'b0, 1, lat);
        checks++;
        if ({ovf, cout, sum} !== e || lat !== NS) begin
            errors++;
            $display("FAIL bp_ignore_run: ovf/cout/sum=%b/%b/%h lat=%0d, want %b/%b/%h lat=%0d",
                     ovf, cout, sum, lat, e[W+1], e[W], e[W-1:0], NS);
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== e) stable = 0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold: vld=%b rdy=%b sum=%h, want 1 0 %h", out_valid, in_ready, sum, e[W-1:0]);
        end
        release_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== e[W-1:0]) begin
            errors++;
            $display("FAIL bp_release: rdy=%b vld=%b sum=%h, want 1 0 %h", in_ready, out_valid, sum, e[W-1:0]);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit seen = 0;
        a = 16'h1234; b = 16'h4321; cin = 0; sub = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || sum !== '0) begin
            errors++;
            $display("FAIL abort: rdy/vld/busy=%b sum=%h, want 100 sum=0000", {in_ready, out_valid, busy}, sum);
        end
        repeat (8) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_valid: out_valid seen=1, want 0");
        end
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, lat);
        checks++;
        if (sum !== 16'h0002 || lat !== NS) begin
            errors++;
            $display("FAIL abort_next: sum=%h lat=%0d, want 0002 lat=%0d", sum, lat, NS);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$], qb[$];
        logic qc[$], qs[$];
        logic [W+1:0] exp_q[$];
        logic [W+1:0] e;
        int acc_cyc[$];
        int cyc = 0, results = 0;
        bit acc;
        for (int i = 0; i < 3; i++) begin
            qa.push_back(W'($urandom)); qb.push_back(W'($urandom));
            qc.push_back(1'($urandom)); qs.push_back(i == 1);
        end
        out_ready = 1;
        while (results < 3 && cyc < 100) begin
            if (qa.size() > 0) begin
                a = qa[0]; b = qb[0]; cin = qc[0]; sub = qs[0]; in_valid = 1;
            end else in_valid = 0;
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                results++;
                checks++;
                if ({ovf, cout, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: ovf/cout/sum=%b/%b/%h, want %b/%b/%h",
                             results, ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                exp_q.push_back(model(qa[0], qb[0], qc[0], qs[0]));
                void'(qa.pop_front()); void'(qb.pop_front());
                void'(qc.pop_front()); void'(qs.pop_front());
                acc_cyc.push_back(cyc);
            end
        end
        out_ready = 0; in_valid = 0;
        checks++;
        if (results != 3 || acc_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_timeout: results=%0d accepts=%0d, want 3 3", results, acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != NS + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: %0d cycles, want %0d", i, acc_cyc[i] - acc_cyc[i-1], NS + 2);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] x, y;
        logic c, s;
        logic [W+1:0] e;
        for (int i = 0; i < 16; i++) begin
            x = W'($urandom); y = W'($urandom);
            c = 1'($urandom); s = 1'($urandom);
            e = model(x, y, c, s);
            do_op(x, y, c, s, 0, lat);
            checks++;
            if ({ovf, cout, sum} !== e || lat !== NS) begin
                errors++;
                $display("FAIL random%0d %h%s%h c%b: ovf/cout/sum=%b/%b/%h lat=%0d, want %b/%b/%h lat=%0d",
                         i, x, s ? "-" : "+", y, c, ovf, cout, sum, lat, e[W+1], e[W], e[W-1:0], NS);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            release_result();
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_directed(16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
        test_directed(16'hffff, 16'h0001, 1'b0, 1'b0, "add_ripple");
        test_directed(16'h7fff, 16'h0001, 1'b0, 1'b0, "add_ovf");
        test_directed(16'h8000, 16'h0001, 1'b1, 1'b1, "sub_ovf");
        test_directed(16'h0003, 16'h0005, 1'b1, 1'b1, "sub_borrow");
        test_directed(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf_cin0");
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
